sdram_burst_ctrl: RTL and testbench
===================================

SDRAM_BURST_CTRL -- requirements
Module: sdram_burst_ctrl

Interface
REQ-001 The block SHALL provide parameter ADDR_WID, default 27, meaning Avalon address width in words.
REQ-002 The block SHALL provide parameter DATA_WID, default 32, meaning data width.
REQ-003 The block SHALL provide parameter MAX_BURST, default 8, meaning maximum beats per burst (power of two, 1..64).
REQ-004 The block SHALL provide parameter INIT_LAST_ADDR, default {ADDR_WID{1'b1}}, meaning last word written by init; INIT_LAST_ADDR+1 SHALL be a multiple of MAX_BURST.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset: CLK in 1 system clock; RESET_N in 1 synchronous active-low reset.
REQ-006 The block SHALL have these slave ports: AVM_S0_INIT in 1 start fill; AVM_S0_READ in 1; AVM_S0_WRITE in 1; AVM_S0_ADDRESS in ADDR_WID; AVM_S0_BURSTCOUNT in 7; AVM_S0_WRITEDATA in DATA_WID; AVM_S0_WAITREQUEST out 1; AVM_S0_READDATA out DATA_WID; AVM_S0_READDATAVALID out 1; AVM_S0_INITCOMPLETE out 1.
REQ-007 The block SHALL have these master ports: AVM_M0_WAITREQUEST in 1; AVM_M0_READDATA in DATA_WID; AVM_M0_READDATAVALID in 1; AVM_M0_READ out 1; AVM_M0_WRITE out 1; AVM_M0_ADDRESS out ADDR_WID; AVM_M0_WRITEDATA out DATA_WID; AVM_M0_BURSTCOUNT out 7.

Function
REQ-008 The block SHALL use states IDLE, INIT, WR, RD_CMD and RD_DATA.
REQ-009 The block SHALL drive AVM_S0_WAITREQUEST low in IDLE. In IDLE, a command is accepted on a clock edge with priority INIT > READ > WRITE.
REQ-010 The block SHALL treat an effective burst length of 0 as 1 and SHALL clamp values above MAX_BURST to MAX_BURST. The effective length SHALL be latched at acceptance.
REQ-011 When a write is accepted in IDLE, the block SHALL latch the address, the length and beat 0 into a one-entry holding register (wr_valid=1), then enter WR.
REQ-012 In WR, AVM_M0_WRITE SHALL equal wr_valid, AVM_M0_ADDRESS SHALL hold the latched start address, and AVM_M0_BURSTCOUNT SHALL hold the latched length.
REQ-013 In WR, AVM_S0_WAITREQUEST SHALL be low only while beats remain and (wr_valid=0 or AVM_M0_WAITREQUEST=0). This gives zero-bubble streaming.
REQ-014 Master write outputs SHALL remain stable while AVM_M0_WAITREQUEST=1. When the final beat is accepted by the master, the block SHALL go to IDLE.
REQ-015 When a read is accepted, the block SHALL enter RD_CMD. AVM_M0_READ SHALL be 1 with the latched address and length until AVM_M0_WAITREQUEST=0, then the block SHALL enter RD_DATA.
REQ-016 In RD_DATA, each AVM_M0_READDATAVALID beat SHALL be registered to AVM_S0_READDATA and AVM_S0_READDATAVALID (1-cycle latency). After the last beat, the block SHALL return to IDLE in the same edge.
REQ-017 The block SHALL ignore AVM_M0_READDATAVALID outside RD_DATA.
REQ-018 When INIT is accepted, the block SHALL clear AVM_S0_INITCOMPLETE and write from address 0 to INIT_LAST_ADDR in MAX_BURST-beat bursts, advancing the address by MAX_BURST per burst. Data SHALL be zero unless REQ-024 applies.
REQ-019 The block SHALL set AVM_S0_INITCOMPLETE when the final init beat is accepted, then go to IDLE. The flag SHALL stay set until the next INIT or reset.
REQ-020 The beat counter and address SHALL be sized so that the end condition of INIT_LAST_ADDR = all-ones causes no wrap before completion.
REQ-021 AVM_S0_WAITREQUEST SHALL be 1 in INIT, RD_CMD and RD_DATA.

Reset
REQ-022 While RESET_N=0 at a clock edge, the block SHALL go to IDLE and clear every output, counter and wr_valid. Outputs SHALL be low or zero, except AVM_M0_BURSTCOUNT, which SHALL be 1.
REQ-023 Reset mid-burst SHALL abandon the transfer with no further master beats. Read beats that arrive later SHALL be ignored.

Configuration
REQ-024 With macro SDRAM_INIT_PATTERN_EN defined, init write data SHALL equal the word address, zero-extended or truncated to DATA_WID. Without it, init write data SHALL be all-zero and the pattern logic SHALL be absent.

Structure
REQ-025 Package sdram_ctrl_pkg SHALL hold the state enum, the burstcount width constant (7) and a clamp function for burst length.
REQ-026 The init address and beat generator SHALL be the sub-module sdram_init_seq, which provides start, advance, addr, last and data outputs.

Verification
REQ-027 The bench SHALL cover INIT with INIT_LAST_ADDR=63 and MAX_BURST=8, no master waits: exactly 8 bursts of 8 beats to addresses 0,8,...,56, and INITCOMPLETE set one cycle after beat 64.
REQ-028 The bench SHALL cover a write with length 4 to 0x100 and data A,B,C,D while the master asserts waitrequest for 3 cycles on beat 1: master sees A,B,C,D in order and data stays stable during the wait.
REQ-029 The bench SHALL cover a read with length 0 to 0x20, where the master returns 0xDEAD: one master read with burstcount 1, and S0 readdatavalid with 0xDEAD one cycle after the master valid.
REQ-030 The bench SHALL cover INIT, READ and WRITE asserted together in IDLE: INIT wins and the other requests are not accepted.
REQ-031 The bench SHALL cover RESET_N low in RD_DATA after 2 of 8 beats: state goes to IDLE, outputs clear, and the 6 late beats produce no S0 readdatavalid.
REQ-032 The bench SHALL cover SDRAM_INIT_PATTERN_EN defined: the beat written to address 0x35 carries data 0x35.

Source files
------------

// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDRAM burst controller.
//   state_e        - controller FSM states
//   BURSTCOUNT_WID - width of the Avalon burstcount field
//   clamp_burst()  - maps a requested burst length onto 1..max_burst
package sdram_ctrl_pkg;

    localparam int unsigned BURSTCOUNT_WID = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        WR      = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4
    } state_e;

    // A request of 0 beats means one beat; anything longer than max_burst is cut to max_burst.
    function automatic logic [BURSTCOUNT_WID-1:0] clamp_burst(
        input logic [BURSTCOUNT_WID-1:0] req,
        input int unsigned               max_burst
    );
        if (req == '0) begin
            return BURSTCOUNT_WID'(1);
        end
        if (32'(req) > max_burst) begin
            return BURSTCOUNT_WID'(max_burst);
        end
        return req;
    endfunction

endpackage

// File: rtl/sdram_burst_ctrl_if.sv
// Avalon-MM burst bus used on both sides of the SDRAM burst controller.
//   slave  modport - controller's upstream (S0) view: commands in, waitrequest/read data out
//   master modport - controller's downstream (M0) view: commands out, waitrequest/read data in
// init/initcomplete are only meaningful on the slave side.
interface sdram_burst_ctrl_if
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WID = 27,
    parameter int unsigned DATA_WID = 32
) ();

    logic                      init;
    logic                      read;
    logic                      write;
    logic [ADDR_WID-1:0]       address;
    logic [BURSTCOUNT_WID-1:0] burstcount;
    logic [DATA_WID-1:0]       writedata;
    logic                      waitrequest;
    logic [DATA_WID-1:0]       readdata;
    logic                      readdatavalid;
    logic                      initcomplete;

    modport slave (
        input  init, read, write, address, burstcount, writedata,
        output waitrequest, readdata, readdatavalid, initcomplete
    );

    modport master (
        output read, write, address, burstcount, writedata,
        input  waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/sdram_init_seq.sv
// Address/data generator for the memory fill performed on INIT.
//   CLK, RESET_N - clock, synchronous active-low reset
//   start        - restart the fill at word 0
//   advance      - the current beat was accepted by the memory
//   addr         - start address of the burst containing the current beat
//   last         - current beat is the final word (INIT_LAST_ADDR)
//   data         - write data for the current beat
// Macro SDRAM_INIT_PATTERN_EN: data is the word address instead of zero.
module sdram_init_seq #(
    parameter int unsigned         ADDR_WID       = 27,
    parameter int unsigned         DATA_WID       = 32,
    parameter int unsigned         MAX_BURST      = 8,
    parameter logic [ADDR_WID-1:0] INIT_LAST_ADDR = {ADDR_WID{1'b1}}
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                start,
    input  logic                advance,
    output logic [ADDR_WID-1:0] addr,
    output logic                last,
    output logic [DATA_WID-1:0] data
);

    localparam logic [ADDR_WID-1:0] BEAT_MASK = ADDR_WID'(MAX_BURST - 1);

    // Word address of the current beat. The fill stops on last, so reaching all-ones never wraps.
    logic [ADDR_WID-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (start) begin
            word_d = '0;
        end else if (advance) begin
            word_d = word_q + ADDR_WID'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    // Bursts are MAX_BURST-aligned from 0, so the burst base is the word with its beat bits cleared.
    assign addr = word_q & ~BEAT_MASK;
    assign last = (word_q == INIT_LAST_ADDR);

`ifdef SDRAM_INIT_PATTERN_EN
    assign data = DATA_WID'(word_q);
`else
    assign data = '0;
`endif

endmodule

// File: rtl/sdram_burst_ctrl.sv
// Avalon-MM burst bridge in front of an SDRAM controller, with a memory-fill (INIT) engine.
//   CLK, RESET_N - clock, synchronous active-low reset
//   avm_s0       - upstream slave: init/read/write commands, write stream, registered read data
//   avm_m0       - downstream master: burst commands, write beats, read data returns
// Macro SDRAM_INIT_PATTERN_EN (in sdram_init_seq): init data = word address instead of zero.
module sdram_burst_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned         ADDR_WID       = 27,
    parameter int unsigned         DATA_WID       = 32,
    parameter int unsigned         MAX_BURST      = 8,
    parameter logic [ADDR_WID-1:0] INIT_LAST_ADDR = {ADDR_WID{1'b1}}
) (
    input logic                CLK,
    input logic                RESET_N,
    sdram_burst_ctrl_if.slave  avm_s0,
    sdram_burst_ctrl_if.master avm_m0
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_INIT    = INIT;
    localparam logic [2:0] S_WR      = WR;
    localparam logic [2:0] S_RD_CMD  = RD_CMD;
    localparam logic [2:0] S_RD_DATA = RD_DATA;

    logic [2:0]                state_q, state_d;
    logic [ADDR_WID-1:0]       addr_q, addr_d;
    logic [BURSTCOUNT_WID-1:0] len_q, len_d;
    logic [DATA_WID-1:0]       wr_data_q, wr_data_d;
    logic                      wr_valid_q, wr_valid_d;
    logic [BURSTCOUNT_WID-1:0] s_left_q, s_left_d;   // upstream write beats still to accept
    logic [BURSTCOUNT_WID-1:0] m_left_q, m_left_d;   // beats still to pass to/from the master
    logic [DATA_WID-1:0]       rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      init_done_q, init_done_d;

    logic                      s0_wait;
    logic                      m0_read, m0_write;
    logic [ADDR_WID-1:0]       m0_addr;
    logic [DATA_WID-1:0]       m0_wdata;
    logic [BURSTCOUNT_WID-1:0] m0_bc, req_len;
    logic                      m_acc, s_acc;
    logic                      seq_start, seq_adv, seq_last;
    logic [ADDR_WID-1:0]       seq_addr;
    logic [DATA_WID-1:0]       seq_data;

    sdram_init_seq #(
        .ADDR_WID       (ADDR_WID),
        .DATA_WID       (DATA_WID),
        .MAX_BURST      (MAX_BURST),
        .INIT_LAST_ADDR (INIT_LAST_ADDR)
    ) u_init_seq (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (seq_start),
        .advance (seq_adv),
        .addr    (seq_addr),
        .last    (seq_last),
        .data    (seq_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = wr_valid_q;
        s_left_d    = s_left_q;
        m_left_d    = m_left_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        init_done_d = init_done_q;
        s0_wait     = 1'b1;
        m0_read     = 1'b0;
        m0_write    = 1'b0;
        m0_addr     = addr_q;
        m0_wdata    = wr_data_q;
        m0_bc       = len_q;
        m_acc       = 1'b0;
        s_acc       = 1'b0;
        seq_start   = 1'b0;
        seq_adv     = 1'b0;
        req_len     = clamp_burst(avm_s0.burstcount, MAX_BURST);

        case (state_q)
            S_IDLE: begin
                s0_wait = 1'b0;
                if (avm_s0.init) begin
                    seq_start   = 1'b1;
                    init_done_d = 1'b0;
                    addr_d      = '0;
                    len_d       = BURSTCOUNT_WID'(MAX_BURST);
                    state_d     = S_INIT;
                end else if (avm_s0.read) begin
                    addr_d  = avm_s0.address;
                    len_d   = req_len;
                    state_d = S_RD_CMD;
                end else if (avm_s0.write) begin
                    addr_d     = avm_s0.address;
                    len_d      = req_len;
                    wr_data_d  = avm_s0.writedata;
                    wr_valid_d = 1'b1;
                    s_left_d   = req_len - BURSTCOUNT_WID'(1);
                    m_left_d   = req_len;
                    state_d    = S_WR;
                end
            end

            S_INIT: begin
                m0_write = 1'b1;
                m0_addr  = seq_addr;
                m0_wdata = seq_data;
                if (!avm_m0.waitrequest) begin
                    seq_adv = 1'b1;
                    if (seq_last) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_WR: begin
                m0_write = wr_valid_q;
                // Refill the holding register in the same cycle the master drains it.
                s0_wait  = !((s_left_q != '0) && (!wr_valid_q || !avm_m0.waitrequest));
                m_acc    = wr_valid_q && !avm_m0.waitrequest;
                s_acc    = !s0_wait && avm_s0.write;
                if (m_acc) begin
                    wr_valid_d = 1'b0;
                    m_left_d   = m_left_q - BURSTCOUNT_WID'(1);
                end
                if (s_acc) begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = avm_s0.writedata;
                    s_left_d   = s_left_q - BURSTCOUNT_WID'(1);
                end
                if (m_acc && (m_left_q == BURSTCOUNT_WID'(1))) begin
                    state_d = S_IDLE;
                end
            end

            S_RD_CMD: begin
                m0_read = 1'b1;
                if (!avm_m0.waitrequest) begin
                    m_left_d = len_q;
                    state_d  = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (avm_m0.readdatavalid) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = avm_m0.readdata;
                    m_left_d   = m_left_q - BURSTCOUNT_WID'(1);
                    if (m_left_q == BURSTCOUNT_WID'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= BURSTCOUNT_WID'(1);
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            s_left_q    <= '0;
            m_left_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            s_left_q    <= s_left_d;
            m_left_q    <= m_left_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            init_done_q <= init_done_d;
        end
    end

    assign avm_s0.waitrequest   = s0_wait;
    assign avm_s0.readdata      = rd_data_q;
    assign avm_s0.readdatavalid = rd_valid_q;
    assign avm_s0.initcomplete  = init_done_q;
    assign avm_m0.read          = m0_read;
    assign avm_m0.write         = m0_write;
    assign avm_m0.address       = m0_addr;
    assign avm_m0.writedata     = m0_wdata;
    assign avm_m0.burstcount    = m0_bc;

endmodule

// File: tb/tb_sdram_burst_ctrl.sv
// Self-checking bench for sdram_burst_ctrl (ADDR_WID=27, DATA_WID=32, MAX_BURST=8,
// INIT_LAST_ADDR=63). Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sdram_burst_ctrl;

    localparam int unsigned AW   = 27;
    localparam int unsigned DW   = 32;
    localparam int unsigned MB   = 8;
    localparam int unsigned LAST = 63;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] exp_data_q[$];
    logic [AW-1:0] exp_addr_q[$];

    sdram_burst_ctrl_if #(.ADDR_WID(AW), .DATA_WID(DW)) s0_if ();
    sdram_burst_ctrl_if #(.ADDR_WID(AW), .DATA_WID(DW)) m0_if ();

    sdram_burst_ctrl #(
        .ADDR_WID       (AW),
        .DATA_WID       (DW),
        .MAX_BURST      (MB),
        .INIT_LAST_ADDR (AW'(LAST))
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .avm_s0  (s0_if),
        .avm_m0  (m0_if)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int n);
`ifdef SDRAM_INIT_PATTERN_EN
        return DW'(n);
`else
        return '0;
`endif
    endfunction

    task automatic idle_inputs();
        s0_if.init          = 1'b0;
        s0_if.read          = 1'b0;
        s0_if.write         = 1'b0;
        s0_if.address       = '0;
        s0_if.burstcount    = '0;
        s0_if.writedata     = '0;
        m0_if.init          = 1'b0;
        m0_if.initcomplete  = 1'b0;
        m0_if.waitrequest   = 1'b0;
        m0_if.readdata      = '0;
        m0_if.readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (s0_if.waitrequest !== 1'b0 || s0_if.readdatavalid !== 1'b0 ||
            s0_if.initcomplete !== 1'b0) begin
            errors++;
            $display("FAIL reset_s0_flags: wait=%b rdvalid=%b initdone=%b, required 0 0 0",
                     s0_if.waitrequest, s0_if.readdatavalid, s0_if.initcomplete);
        end
        checks++;
        if (s0_if.readdata !== '0) begin
            errors++;
            $display("FAIL reset_s0_readdata: got %h, required 0", s0_if.readdata);
        end
        checks++;
        if (m0_if.read !== 1'b0 || m0_if.write !== 1'b0 || m0_if.address !== '0 ||
            m0_if.writedata !== '0) begin
            errors++;
            $display("FAIL reset_m0: rd=%b wr=%b addr=%h wdata=%h, required 0 0 0 0",
                     m0_if.read, m0_if.write, m0_if.address, m0_if.writedata);
        end
        checks++;
        if (m0_if.burstcount !== 7'd1) begin
            errors++;
            $display("FAIL reset_m0_burstcount: got %0d, required 1", m0_if.burstcount);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        int            beats = 0;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        for (int n = 0; n <= int'(LAST); n++) begin
            exp_addr_q.push_back(AW'((n / int'(MB)) * int'(MB)));
            exp_data_q.push_back(init_word(n));
        end
        for (int cyc = 0; cyc < 200 && beats <= int'(LAST); cyc++) begin
            @(negedge clk);
            s0_if.init        = (cyc == 0);
            m0_if.waitrequest = 1'b0;
            #1;
            if (cyc == 1) begin
                checks++;
                if (s0_if.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL init_waitreq: got %b, required 1", s0_if.waitrequest);
                end
            end
            if (m0_if.write === 1'b1 && m0_if.waitrequest === 1'b0) begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                checks++;
                if (m0_if.address !== ea || m0_if.writedata !== ed || m0_if.burstcount !== 7'd8) begin
                    errors++;
                    $display("FAIL init_beat%0d: addr=%h data=%h bc=%0d, required %h %h 8",
                             beats, m0_if.address, m0_if.writedata, m0_if.burstcount, ea, ed);
                end
                beats++;
                if (beats == int'(LAST) + 1) begin
                    checks++;
                    if (s0_if.initcomplete !== 1'b0) begin
                        errors++;
                        $display("FAIL init_early_done: got %b, required 0", s0_if.initcomplete);
                    end
                end
            end
        end
        checks++;
        if (beats != int'(LAST) + 1) begin
            errors++;
            $display("FAIL init_beat_count: got %0d, required %0d", beats, LAST + 1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (s0_if.initcomplete !== 1'b1 || m0_if.write !== 1'b0 || s0_if.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL init_done: initdone=%b m0wr=%b wait=%b, required 1 0 0",
                     s0_if.initcomplete, m0_if.write, s0_if.waitrequest);
        end
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic test_write();
        logic [DW-1:0] wd [4];
        logic [DW-1:0] ed;
        int            hi = 0;
        int            mb = 0;
        int            stall = 0;
        wd[0] = 32'hAAAA_0001;
        wd[1] = 32'hBBBB_0002;
        wd[2] = 32'hCCCC_0003;
        wd[3] = 32'hDDDD_0004;
        for (int i = 0; i < 4; i++) exp_data_q.push_back(wd[i]);
        for (int cyc = 0; cyc < 60 && mb < 4; cyc++) begin
            @(negedge clk);
            s0_if.address    = AW'(32'h100);
            s0_if.burstcount = 7'd4;
            if (hi < 4) begin
                s0_if.write     = 1'b1;
                s0_if.writedata = wd[hi];
            end else begin
                s0_if.write     = 1'b0;
                s0_if.writedata = '0;
            end
            m0_if.waitrequest = 1'b0;
            if (mb == 1 && m0_if.write === 1'b1 && stall < 3) begin
                m0_if.waitrequest = 1'b1;
                stall++;
            end
            #1;
            if (m0_if.write === 1'b1) begin
                if (m0_if.waitrequest) begin
                    checks++;
                    if (m0_if.writedata !== exp_data_q[0] || m0_if.address !== AW'(32'h100) ||
                        m0_if.burstcount !== 7'd4) begin
                        errors++;
                        $display("FAIL write_stable: data=%h addr=%h bc=%0d, required %h 100 4",
                                 m0_if.writedata, m0_if.address, m0_if.burstcount, exp_data_q[0]);
                    end
                end else begin
                    ed = exp_data_q.pop_front();
                    checks++;
                    if (m0_if.writedata !== ed || m0_if.address !== AW'(32'h100) ||
                        m0_if.burstcount !== 7'd4) begin
                        errors++;
                        $display("FAIL write_beat%0d: data=%h addr=%h bc=%0d, required %h 100 4",
                                 mb, m0_if.writedata, m0_if.address, m0_if.burstcount, ed);
                    end
                    mb++;
                end
            end
            if (s0_if.write && s0_if.waitrequest === 1'b0) hi++;
        end
        checks++;
        if (mb != 4 || stall != 3 || hi != 4) begin
            errors++;
            $display("FAIL write_count: master=%0d stalls=%0d host=%0d, required 4 3 4", mb, stall, hi);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (s0_if.waitrequest !== 1'b0 || m0_if.write !== 1'b0) begin
            errors++;
            $display("FAIL write_idle: wait=%b m0wr=%b, required 0 0", s0_if.waitrequest, m0_if.write);
        end
        exp_data_q.delete();
    endtask

    task automatic test_read(input logic [AW-1:0] addr, input logic [6:0] bc, input int exp_len);
        int            cmds = 0;
        int            sent = 0;
        int            got = 0;
        int            delay = -1;
        logic          prev_mv = 1'b0;
        logic [DW-1:0] md;
        logic [DW-1:0] ed;
        for (int cyc = 0; cyc < 60 && got < exp_len; cyc++) begin
            @(negedge clk);
            s0_if.read          = (cyc == 0);
            s0_if.address       = addr;
            s0_if.burstcount    = bc;
            m0_if.waitrequest   = 1'b0;
            m0_if.readdatavalid = 1'b0;
            if (delay == 0 && sent < exp_len) begin
                md = (exp_len == 1) ? 32'h0000_DEAD : (32'hBEEF_0000 | DW'(sent));
                m0_if.readdatavalid = 1'b1;
                m0_if.readdata      = md;
                exp_data_q.push_back(md);
                sent++;
            end else if (delay > 0) begin
                delay--;
            end
            #1;
            if (m0_if.read === 1'b1 && m0_if.waitrequest === 1'b0) begin
                cmds++;
                delay = 1;
                checks++;
                if (m0_if.address !== addr || m0_if.burstcount !== 7'(exp_len) ||
                    s0_if.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL read_cmd: addr=%h bc=%0d wait=%b, required %h %0d 1",
                             m0_if.address, m0_if.burstcount, s0_if.waitrequest, addr, exp_len);
                end
            end
            if (s0_if.readdatavalid === 1'b1) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_spurious: data=%h, required no valid", s0_if.readdata);
                end else begin
                    ed = exp_data_q.pop_front();
                    if (s0_if.readdata !== ed || !prev_mv) begin
                        errors++;
                        $display("FAIL read_beat%0d: data=%h prev_m0_valid=%b, required %h 1",
                                 got, s0_if.readdata, prev_mv, ed);
                    end
                end
                got++;
            end
            prev_mv = m0_if.readdatavalid;
        end
        checks++;
        if (cmds != 1 || got != exp_len) begin
            errors++;
            $display("FAIL read_count: cmds=%0d beats=%0d, required 1 %0d", cmds, got, exp_len);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (s0_if.waitrequest !== 1'b0 || m0_if.read !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: wait=%b m0rd=%b, required 0 0", s0_if.waitrequest, m0_if.read);
        end
        exp_data_q.delete();
    endtask

    task automatic test_priority();
        int   beats = 0;
        int   reads = 0;
        logic done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            s0_if.init        = (cyc == 0);
            s0_if.read        = (cyc == 0);
            s0_if.write       = (cyc == 0);
            s0_if.address     = AW'(32'h40);
            s0_if.burstcount  = 7'd2;
            s0_if.writedata   = 32'h1234_5678;
            m0_if.waitrequest = 1'b0;
            #1;
            if (cyc == 1) begin
                checks++;
                if (m0_if.write !== 1'b1 || m0_if.read !== 1'b0 || m0_if.address !== '0 ||
                    m0_if.burstcount !== 7'd8) begin
                    errors++;
                    $display("FAIL prio_init_won: wr=%b rd=%b addr=%h bc=%0d, required 1 0 0 8",
                             m0_if.write, m0_if.read, m0_if.address, m0_if.burstcount);
                end
                checks++;
                if (s0_if.initcomplete !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_initdone_clear: got %b, required 0", s0_if.initcomplete);
                end
            end
            if (m0_if.read === 1'b1) reads++;
            if (m0_if.write === 1'b1 && m0_if.waitrequest === 1'b0) beats++;
            if (cyc > 1 && s0_if.initcomplete === 1'b1) done = 1'b1;
        end
        checks++;
        if (beats != int'(LAST) + 1 || reads != 0 || !done) begin
            errors++;
            $display("FAIL prio_count: beats=%0d reads=%0d done=%b, required %0d 0 1",
                     beats, reads, done, LAST + 1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m0_if.read !== 1'b0 || m0_if.write !== 1'b0 || s0_if.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL prio_no_pending: rd=%b wr=%b wait=%b, required 0 0 0",
                     m0_if.read, m0_if.write, s0_if.waitrequest);
        end
    endtask

    task automatic test_reset_mid_read();
        int            pre = 0;
        int            late = 0;
        logic [DW-1:0] ed;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            s0_if.read          = (cyc == 0);
            s0_if.address       = AW'(32'h80);
            s0_if.burstcount    = 7'd8;
            m0_if.waitrequest   = 1'b0;
            rst_n               = (cyc != 4);
            m0_if.readdatavalid = (cyc == 2 || cyc == 3 || (cyc >= 5 && cyc <= 10));
            m0_if.readdata      = 32'h5A5A_0000 | DW'(cyc);
            if (cyc == 2 || cyc == 3) exp_data_q.push_back(32'h5A5A_0000 | DW'(cyc));
            #1;
            if (cyc == 1) begin
                checks++;
                if (m0_if.read !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_rd_cmd: m0rd=%b, required 1", m0_if.read);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (s0_if.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_rd_busy: wait=%b, required 1", s0_if.waitrequest);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (s0_if.waitrequest !== 1'b0 || s0_if.readdatavalid !== 1'b0 ||
                    s0_if.readdata !== '0 || m0_if.read !== 1'b0 || m0_if.write !== 1'b0 ||
                    m0_if.address !== '0 || m0_if.burstcount !== 7'd1) begin
                    errors++;
                    $display("FAIL rst_cleared: wait=%b rv=%b rd=%h m0rd=%b m0wr=%b addr=%h bc=%0d, required 0 0 0 0 0 0 1",
                             s0_if.waitrequest, s0_if.readdatavalid, s0_if.readdata, m0_if.read,
                             m0_if.write, m0_if.address, m0_if.burstcount);
                end
            end
            if (s0_if.readdatavalid === 1'b1) begin
                if (cyc <= 4 && exp_data_q.size() != 0) begin
                    ed = exp_data_q.pop_front();
                    checks++;
                    if (s0_if.readdata !== ed) begin
                        errors++;
                        $display("FAIL rst_pre_beat: data=%h, required %h", s0_if.readdata, ed);
                    end
                    pre++;
                end else begin
                    late++;
                end
            end
        end
        checks++;
        if (pre != 2 || late != 0) begin
            errors++;
            $display("FAIL rst_late_beats: before=%0d after=%0d, required 2 0", pre, late);
        end
        idle_inputs();
        exp_data_q.delete();
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_read(AW'(32'h20), 7'd0, 1);
        test_read(AW'(32'h10), 7'd100, int'(MB));
        test_priority();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
